prefetcher_r_responder: RTL
===========================

# prefetcher_r_responder

Master-facing AXI read-data (R) responder for the prefetcher. Drains data blocks from the prefetcher data queue whenever the queue reports a promised block ready and issues the queue's promise-read opcode. It then returns each block to the master as an AXI R beat with the correct ID, RLAST and an elastic 2-entry output buffer. It sits between the prefetcher data queue and the master's R channel; the AR side only supplies accepted-request IDs.

## Interface
- LOG_BLOCK_DATA_BYTES, 6: block size log2 [bytes]; data width DW = 8<<LOG_BLOCK_DATA_BYTES bits
- LOG_QUEUE_SIZE, 8: queue depth log2; burst-length field width
- ID_BITS, 4: AXI ID width
- LOG_ID_DEPTH, 3: outstanding-ID FIFO depth log2 (2^LOG_ID_DEPTH entries)
- clk  in  1  clock
- resetN  in  1  asynchronous, active-low reset
- arAccept  in  1  master AR handshake completed this cycle (arvalid&arready)
- arId  in  ID_BITS  ID of accepted AR
- reqBurstLen  in  LOG_QUEUE_SIZE  AXI ARLEN (beats-1), static during operation
- pr_r_valid  in  1  queue has a promised block ready at head
- respData  in  DW  queue head data (valid when pr_r_valid)
- respLast  in  1  queue head last flag
- pr_pop  out  1  promise-read strobe; queue controller issues opcode 4 this cycle
- m_rvalid  out  1  AXI RVALID
- m_rready  in  1  AXI RREADY
- m_rdata  out  DW  AXI RDATA
- m_rlast  out  1  AXI RLAST
- m_rid  out  ID_BITS  AXI RID
- m_rresp  out  2  AXI RRESP, constant 2'b00
- idFull  out  1  ID FIFO full; AR side must deassert arready
- errorCode  out  2  0 none, 1 pop without ID, 2 ID FIFO overflow, 3 last/beat mismatch

## Operation
- ID FIFO: push arId on arAccept; pop at R handshake with m_rlast=1. Simultaneous push/pop on a full FIFO is legal, and occupancy stays unchanged. Pushing when full while not popping drops the ID and sets errorCode=2.
- Output buffer: 2 entries {data, last, id}, FIFO order; head drives m_rdata/m_rlast/m_rid; m_rvalid = buffer non-empty.
- pr_pop = pr_r_valid & (buffer count < 2, counting a same-cycle R handshake as freeing a slot) & ID FIFO non-empty. This is a combinational output; it is 0 while resetN=0.
- On pr_pop, capture respData/respLast and the ID FIFO head into the buffer tail on the same edge the queue consumes the block.
- FSM: IDLE and BURST.
  - IDLE→BURST on pr_pop with respLast=0.
  - BURST→IDLE on pr_pop with respLast=1.
  - IDLE stays IDLE on a single-beat burst.
  - Beat counter (LOG_QUEUE_SIZE+1 bits) clears in IDLE and increments per pop in BURST.
- ID association: every beat of a burst carries the ID FIFO head. The head advances only after that burst's last beat leaves on R, so a following burst is never tagged early.
  - Consequence: a new burst's first beat is not popped from the queue while a previous burst's last beat is still buffered. pr_pop is additionally gated by "no buffered last".
- errorCode is a registered, one-cycle pulse; the highest code wins.
  - 1: pr_r_valid high, buffer has space, but ID FIFO empty (block not popped).
  - 2: overflow, as above.
  - 3: see Configuration.

## Timing
- Reset values: m_rvalid=0, m_rdata=0, m_rlast=0, m_rid=0, m_rresp=0, idFull=0, errorCode=0; FSM=IDLE, counters and FIFO pointers 0.
- Latency: pr_pop in cycle N → m_rvalid=1 in N+1 (buffer empty case).
- Throughput: 1 beat/cycle with m_rready held high; the buffer absorbs one cycle of rready deassertion without dropping pop rate mid-cycle.
- AXI rule: once m_rvalid=1, m_rdata/m_rlast/m_rid stay stable until the m_rready handshake.
- Pointers wrap modulo depth (power of two).
- resetN asserted mid-burst: all state clears immediately (async), and the in-flight beat is lost. Queue reset is the system's responsibility.

## Configuration
- PREF_R_RESP_ERRCHK_EN defined:
  - Compares the beat counter against reqBurstLen at each pop.
  - Raises errorCode=3 if respLast=1 arrives before beat reqBurstLen, or if respLast=0 arrives at beat reqBurstLen.
  - In the latter case the buffered beat is forced to last=1 and the FSM returns to IDLE.
- Undefined: no beat check. m_rlast follows respLast verbatim, and errorCode never equals 3.

## Structure
- Shared package prefetcher_pkg: errorCode enum, AXI RRESP constants (OKAY=2'b00), FSM state typedef.
- One sub-module: sync_fifo (parameterized width/depth, full/empty/count), instantiated for the ID FIFO and for the 2-entry output buffer.

## Test plan
- Single beat: reqBurstLen=0, arAccept id=5, pr_r_valid with respLast=1, m_rready=1 → pr_pop for one cycle, next cycle m_rvalid=1, m_rid=5, m_rlast=1; FSM stays IDLE.
- Burst of 4: reqBurstLen=3, id=2, four ready blocks D0..D3 with last on D3 → four consecutive beats with rid=2, rlast only on D3; ID FIFO empty afterwards.
- Backpressure: burst of 4 with m_rready low for 3 cycles after the first beat → pr_pop stops after the buffer holds 2, and data stays stable. On release all beats arrive in order; none are lost or duplicated.
- Back-to-back IDs 1 then 7, each with reqBurstLen=1 → beats tagged 1,1,7,7, and no ID-7 block is popped before the ID-1 last beat's handshake.
- Errors:
  - pr_r_valid with no accepted AR → pr_pop=0 and errorCode=1 for one cycle.
  - 2^LOG_ID_DEPTH+1 arAccepts with no drain → idFull=1, then errorCode=2.
- With PREF_R_RESP_ERRCHK_EN, reqBurstLen=3 and respLast=1 on beat 1 → errorCode=3 and FSM returns to IDLE. Without the macro: no error, and rlast is passed through.

Source files
------------

// File: rtl/prefetcher_pkg.sv
// prefetcher_pkg: shared error codes, FSM state and AXI response constants for the prefetcher
package prefetcher_pkg;
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_NO_ID  = 2'd1,
    ERR_ID_OVF = 2'd2,
    ERR_BEAT   = 2'd3
  } err_e;
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;
  localparam logic [1:0] RRESP_OKAY = 2'b00;
endpackage

// File: rtl/prefetcher_r_responder_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO; a push while full is accepted only if a pop frees a slot that cycle
module sync_fifo #(
  parameter int W     = 8,
  parameter int LOG_D = 1
) (
  input  logic           clk,
  input  logic           resetN,
  input  logic           push,
  input  logic           pop,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   dout,
  output logic           full,
  output logic           empty,
  output logic [LOG_D:0] count
);
  localparam int D = 1 << LOG_D;
  logic [W-1:0] mem_q [D];
  logic [W-1:0] mem_d [D];
  logic [LOG_D-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LOG_D:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (LOG_D+1)'(D);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d  = wr_q + LOG_D'(do_push);
    rd_d  = rd_q + LOG_D'(do_pop);
    cnt_d = cnt_q + (LOG_D+1)'(do_push) - (LOG_D+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/prefetcher_r_responder.sv
// prefetcher_r_responder: drains promised queue blocks into AXI R beats tagged with the outstanding AR ID.
// Define PREF_R_RESP_ERRCHK_EN to check respLast against reqBurstLen (errorCode 3, forced last).
module prefetcher_r_responder
  import prefetcher_pkg::*;
#(
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int LOG_QUEUE_SIZE       = 8,
  parameter int ID_BITS              = 4,
  parameter int LOG_ID_DEPTH         = 3
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                arAccept,
  input  logic [ID_BITS-1:0]                  arId,
  input  logic [LOG_QUEUE_SIZE-1:0]           reqBurstLen,
  input  logic                                pr_r_valid,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] respData,
  input  logic                                respLast,
  output logic                                pr_pop,
  output logic                                m_rvalid,
  input  logic                                m_rready,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] m_rdata,
  output logic                                m_rlast,
  output logic [ID_BITS-1:0]                  m_rid,
  output logic [1:0]                          m_rresp,
  output logic                                idFull,
  output logic [1:0]                          errorCode
);
  localparam int DW = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int BW = DW + 1 + ID_BITS;
  state_e state_q, state_d;
  logic [LOG_QUEUE_SIZE:0] beat_q, beat_d;
  err_e err_q, err_d;
  logic last_buf_q, last_buf_d;
  logic [ID_BITS-1:0] id_head;
  logic id_empty;
  logic [LOG_ID_DEPTH:0] id_cnt;
  logic [BW-1:0] buf_din, buf_dout;
  logic buf_empty, buf_full;
  logic [1:0] buf_cnt;
  logic r_hs, id_pop, space, beat_last, err_beat, unused_ok;
  assign r_hs      = m_rvalid & m_rready;
  assign id_pop    = r_hs & m_rlast;
  assign space     = ~buf_cnt[1] | r_hs;
  // a buffered last beat still owns the ID head, so the next burst must wait for its handshake
  assign pr_pop    = resetN & pr_r_valid & space & ~id_empty & ~last_buf_q;
  assign buf_din   = {respData, beat_last, id_head};
  assign {m_rdata, m_rlast, m_rid} = buf_dout;
  assign m_rvalid  = ~buf_empty;
  assign m_rresp   = RRESP_OKAY;
  assign errorCode = err_q;
  assign unused_ok = ^{id_cnt, buf_full};
  sync_fifo #(.W(ID_BITS), .LOG_D(LOG_ID_DEPTH)) u_id_fifo (
    .clk(clk), .resetN(resetN), .push(arAccept), .pop(id_pop), .din(arId),
    .dout(id_head), .full(idFull), .empty(id_empty), .count(id_cnt)
  );
  sync_fifo #(.W(BW), .LOG_D(1)) u_out_buf (
    .clk(clk), .resetN(resetN), .push(pr_pop), .pop(r_hs), .din(buf_din),
    .dout(buf_dout), .full(buf_full), .empty(buf_empty), .count(buf_cnt)
  );
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      err_q      <= ERR_NONE;
      last_buf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      last_buf_q <= last_buf_d;
    end
  always_comb state_d = pr_pop ? (beat_last ? IDLE : BURST) : state_q;
  always_comb begin
`ifdef PREF_R_RESP_ERRCHK_EN
    err_beat  = pr_pop & (respLast ? beat_q < {1'b0, reqBurstLen} : beat_q == {1'b0, reqBurstLen});
    beat_last = respLast | (beat_q == {1'b0, reqBurstLen});
`else
    err_beat  = 1'b0;
    beat_last = respLast;
`endif
    beat_d     = state_d == IDLE ? '0 : beat_q + (LOG_QUEUE_SIZE+1)'(pr_pop);
    err_d      = err_beat ? ERR_BEAT :
                 (arAccept & idFull & ~id_pop) ? ERR_ID_OVF :
                 (pr_r_valid & space & id_empty) ? ERR_NO_ID : ERR_NONE;
    last_buf_d = (pr_pop & beat_last) | (last_buf_q & ~id_pop);
  end
`ifndef PREF_R_RESP_ERRCHK_EN
  logic unused_cfg;
  assign unused_cfg = ^reqBurstLen;
`endif
endmodule
